vga_timing_rx: RTL and testbench

VGA_TIMING_RX -- requirements
Module: vga_timing_rx

---
 rtl/vga_timing_rx_if.sv | 30 +++
 rtl/vga_timing_rx.sv | 214 +++++++++++++++++++++
 tb/tb_vga_timing_rx.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_rx_if.sv
// vga_timing_rx_if: VGA sync/pixel input bundle plus recovered timing outputs.
// master drives sync/rgb and observes results; slave is the timing receiver.
interface vga_timing_rx_if;
  logic        hsync_in;
  logic        vsync_in;
  logic [23:0] rgb_in;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic        de;
  logic [23:0] rgb_out;
  logic        locked;
  logic        frame_start;
  logic        timing_err;
  logic [10:0] h_total_meas;
  logic [10:0] v_total_meas;

  modport master (
    output hsync_in, vsync_in, rgb_in,
    input  pix_x, pix_y, de, rgb_out,
    input  locked, frame_start, timing_err,
    input  h_total_meas, v_total_meas
  );

  modport slave (
    input  hsync_in, vsync_in, rgb_in,
    output pix_x, pix_y, de, rgb_out,
    output locked, frame_start, timing_err,
    output h_total_meas, v_total_meas
  );
endinterface

// File: rtl/vga_timing_rx.sv
// vga_timing_rx: measures incoming VGA sync timing, locks to it and
// emits registered pixel coordinates, data-enable and gated colour.
// Ports: vga_clk, sys_rst_n (async, active-low), bus (vga_timing_rx_if.slave):
//   in : hsync_in, vsync_in (active-high), rgb_in[23:0]
//   out: pix_x/pix_y[9:0] (3FF when inactive), de, rgb_out[23:0],
//        locked, frame_start, timing_err, h_total_meas/v_total_meas[10:0]
// Option: define VGA_RX_SYNC_WIDTH_CHECK_EN to also check sync pulse widths.
module vga_timing_rx #(
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 525,
  parameter int H_ACT_START = 144,
  parameter int H_VALID     = 640,
  parameter int V_ACT_START = 35,
  parameter int V_VALID     = 480,
  parameter int H_SYNC      = 96,
  parameter int V_SYNC      = 2,
  parameter int LOCK_FRAMES = 2
) (
  input  logic          vga_clk,
  input  logic          sys_rst_n,
  vga_timing_rx_if.slave bus
);

  localparam logic [10:0] PMAX = 11'h7FF;
  localparam logic [10:0] HTOT = 11'(H_TOTAL);
  localparam logic [10:0] VTOT = 11'(V_TOTAL);
  localparam logic [10:0] HA0  = 11'(H_ACT_START);
  localparam logic [10:0] HA1  = 11'(H_ACT_START + H_VALID);
  localparam logic [10:0] VA0  = 11'(V_ACT_START);
  localparam logic [10:0] VA1  = 11'(V_ACT_START + V_VALID);
  localparam int          CW   = $clog2(LOCK_FRAMES + 1);
  localparam logic [CW-1:0] LOCKN = CW'(LOCK_FRAMES);

  if (H_SYNC < 1 || V_SYNC < 1 || LOCK_FRAMES < 1) begin : g_bad_cfg
    $error("vga_timing_rx: H_SYNC, V_SYNC, LOCK_FRAMES must be >= 1");
  end

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t state, state_d;

  logic          hs_q, vs_q;
  logic          hs_rise, vs_rise;
  logic [10:0]   hpos, vpos;
  logic [10:0]   hpos_d, vpos_d;
  logic [10:0]   h_len, v_len;
  logic [CW-1:0] good_cnt, good_cnt_d, cnt_inc;
  logic          bad_seen, bad_seen_d;
  logic          h_ovf, line_bad, frame_good;
  logic          hw_bad, vw_bad;
  logic          de_d;

  logic [9:0]    pix_x, pix_y;
  logic          de;
  logic [23:0]   rgb_out;
  logic          frame_start, timing_err;
  logic [10:0]   h_meas, v_meas;

  assign hs_rise = bus.hsync_in & ~hs_q;
  assign vs_rise = bus.vsync_in & ~vs_q;

  // Saturating +1 doubles as the measured length of the ending line/frame.
  assign h_len = (hpos == PMAX) ? PMAX : hpos + 11'd1;
  assign v_len = (vpos == PMAX) ? PMAX : vpos + 11'd1;

  assign hpos_d = hs_rise ? 11'd0 : h_len;
  assign vpos_d = vs_rise ? 11'd0 :
                  hs_rise ? v_len : vpos;

  // Fires once, on the cycle the line counter first saturates.
  assign h_ovf = (hpos_d == PMAX) && (hpos != PMAX);

`ifdef VGA_RX_SYNC_WIDTH_CHECK_EN
  localparam logic [10:0] HSW = 11'(H_SYNC);
  localparam logic [10:0] VSW = 11'(V_SYNC);

  logic [10:0] hs_w, vs_w;
  logic        hs_fall, vs_fall;

  assign hs_fall = ~bus.hsync_in & hs_q;
  assign vs_fall = ~bus.vsync_in & vs_q;
  assign hw_bad  = hs_fall && (hs_w != HSW);
  assign vw_bad  = vs_fall && (vs_w != VSW);

  // hs_w counts high samples; vs_w counts lines started while vsync high.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      hs_w <= '0;
      vs_w <= '0;
    end else begin
      if (hs_rise)
        hs_w <= 11'd1;
      else if (bus.hsync_in && hs_w != PMAX)
        hs_w <= hs_w + 11'd1;
      if (vs_rise)
        vs_w <= 11'd1;
      else if (bus.vsync_in && hs_rise && vs_w != PMAX)
        vs_w <= vs_w + 11'd1;
    end
  end
`else
  assign hw_bad = 1'b0;
  assign vw_bad = 1'b0;
`endif

  assign line_bad = (hs_rise && (h_len != HTOT)) || hw_bad;

  // A line ending on the vsync edge still belongs to the ending frame.
  assign frame_good = (v_len == VTOT) && !bad_seen && !line_bad;

  assign bad_seen_d = vs_rise ? 1'b0 :
                      (bad_seen | line_bad | vw_bad | h_ovf);

  assign cnt_inc = good_cnt + CW'(1);

  always_comb begin
    state_d    = state;
    good_cnt_d = good_cnt;
    unique case (state)
      SEARCH: begin
        if (vs_rise) begin
          state_d    = CHECK;
          good_cnt_d = '0;
        end
      end
      CHECK: begin
        if (vs_rise) begin
          if (!frame_good) begin
            good_cnt_d = '0;
          end else if (cnt_inc == LOCKN) begin
            state_d    = LOCKED;
            good_cnt_d = '0;
          end else begin
            good_cnt_d = cnt_inc;
          end
        end else if (line_bad || h_ovf) begin
          good_cnt_d = '0;
        end
      end
      LOCKED: begin
        if (line_bad || h_ovf || (vs_rise && !frame_good))
          state_d = SEARCH;
      end
      default: begin
        state_d    = SEARCH;
        good_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= SEARCH;
      good_cnt <= '0;
    end else begin
      state    <= state_d;
      good_cnt <= good_cnt_d;
    end
  end

  // Outputs follow the position of the sample being taken this edge.
  assign de_d = (state_d == LOCKED) &&
                (hpos_d >= HA0) && (hpos_d < HA1) &&
                (vpos_d >= VA0) && (vpos_d < VA1);

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      hs_q        <= 1'b0;
      vs_q        <= 1'b0;
      hpos        <= '0;
      vpos        <= '0;
      bad_seen    <= 1'b0;
      h_meas      <= '0;
      v_meas      <= '0;
      pix_x       <= 10'h3FF;
      pix_y       <= 10'h3FF;
      de          <= 1'b0;
      rgb_out     <= '0;
      frame_start <= 1'b0;
      timing_err  <= 1'b0;
    end else begin
      hs_q        <= bus.hsync_in;
      vs_q        <= bus.vsync_in;
      hpos        <= hpos_d;
      vpos        <= vpos_d;
      bad_seen    <= bad_seen_d;
      if (hs_rise)
        h_meas <= h_len;
      if (vs_rise)
        v_meas <= v_len;
      de          <= de_d;
      pix_x       <= de_d ? 10'(hpos_d - HA0) : 10'h3FF;
      pix_y       <= de_d ? 10'(vpos_d - VA0) : 10'h3FF;
      rgb_out     <= de_d ? bus.rgb_in : 24'h0;
      frame_start <= vs_rise && (state == LOCKED);
      timing_err  <= (state == LOCKED) && (state_d == SEARCH);
    end
  end

  assign bus.pix_x        = pix_x;
  assign bus.pix_y        = pix_y;
  assign bus.de           = de;
  assign bus.rgb_out      = rgb_out;
  assign bus.locked       = (state == LOCKED);
  assign bus.frame_start  = frame_start;
  assign bus.timing_err   = timing_err;
  assign bus.h_total_meas = h_meas;
  assign bus.v_total_meas = v_meas;

endmodule

// File: tb/tb_vga_timing_rx.sv
// tb_vga_timing_rx: directed bench for vga_timing_rx using a short-frame
// (800 x 5 line) sync generator so lock/relock sequences stay quick.
module tb_vga_timing_rx;

  localparam int HT = 800;
  localparam int VT = 5;

`ifdef VGA_RX_SYNC_WIDTH_CHECK_EN
  localparam bit WCHK = 1'b1;
`else
  localparam bit WCHK = 1'b0;
`endif

  logic vga_clk = 1'b0;
  logic sys_rst_n;

  vga_timing_rx_if bus ();

  vga_timing_rx #(
    .H_TOTAL    (800),
    .V_TOTAL    (5),
    .H_ACT_START(144),
    .H_VALID    (640),
    .V_ACT_START(3),
    .V_VALID    (2),
    .H_SYNC     (96),
    .V_SYNC     (2),
    .LOCK_FRAMES(2)
  ) dut (
    .vga_clk  (vga_clk),
    .sys_rst_n(sys_rst_n),
    .bus      (bus)
  );

  always #5 vga_clk = ~vga_clk;

  int cnt_h = 0;
  int cnt_v = 0;
  int h_len = HT;
  int hs_wd = 96;
  bit ovr = 1'b0;
  logic [23:0] ovr_rgb = '0;
  int tests = 0;
  int fails = 0;

  function automatic logic [23:0] pat(int h, int v);
    return {4'hC, 4'(v), 5'd0, 11'(h)};
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one generator sample, clock it in, then advance the counters.
  task automatic step();
    bus.hsync_in = (cnt_h < hs_wd);
    bus.vsync_in = (cnt_v < 2);
    bus.rgb_in   = ovr ? ovr_rgb : pat(cnt_h, cnt_v);
    ovr = 1'b0;
    @(posedge vga_clk);
    #1;
    if (cnt_h == h_len - 1) begin
      cnt_h = 0;
      h_len = HT;
      hs_wd = 96;
      cnt_v = (cnt_v == VT - 1) ? 0 : cnt_v + 1;
    end else begin
      cnt_h++;
    end
  endtask

  // Step until the next sample to be clocked is (h, v).
  task automatic run_to(int h, int v);
    for (int i = 0; i < 10000; i++) begin
      if (cnt_h == h && cnt_v == v) break;
      step();
    end
    if (!(cnt_h == h && cnt_v == v)) begin
      fails++;
      $error("FAIL run_to: stuck at %0d,%0d wanted %0d,%0d",
             cnt_h, cnt_v, h, v);
    end
  endtask

  task automatic relock();
    run_to(0, 0); step();
    run_to(0, 0); step();
    run_to(0, 0); step();
  endtask

  initial begin
    sys_rst_n    = 1'b0;
    bus.hsync_in = 1'b0;
    bus.vsync_in = 1'b0;
    bus.rgb_in   = '0;
    @(posedge vga_clk); #1;
    @(posedge vga_clk); #1;

    chk("rst_pix_x", bus.pix_x, 10'h3FF);
    chk("rst_pix_y", bus.pix_y, 10'h3FF);
    chk("rst_de", bus.de, 1'b0);
    chk("rst_rgb", bus.rgb_out, 24'h0);
    chk("rst_locked", bus.locked, 1'b0);
    chk("rst_fs", bus.frame_start, 1'b0);
    chk("rst_terr", bus.timing_err, 1'b0);
    chk("rst_hmeas", bus.h_total_meas, 11'd0);
    chk("rst_vmeas", bus.v_total_meas, 11'd0);

    // Nominal stream: lock at the vsync ending the second good frame.
    sys_rst_n = 1'b1;
    step();
    chk("lock_f0", bus.locked, 1'b0);
    run_to(0, 0); step();
    chk("lock_f1", bus.locked, 1'b0);
    chk("hmeas_nom", bus.h_total_meas, 11'd800);
    chk("vmeas_nom", bus.v_total_meas, 11'd5);
    run_to(0, 0); step();
    chk("lock_f2", bus.locked, 1'b1);
    chk("fs_at_lock", bus.frame_start, 1'b0);
    chk("terr_at_lock", bus.timing_err, 1'b0);

    // Active window boundaries.
    run_to(144, 2); step();
    chk("de_vporch", bus.de, 1'b0);
    chk("pix_y_vporch", bus.pix_y, 10'h3FF);
    run_to(144, 3);
    ovr = 1'b1;
    ovr_rgb = 24'hABCDEF;
    step();
    chk("first_x", bus.pix_x, 10'd0);
    chk("first_y", bus.pix_y, 10'd0);
    chk("first_de", bus.de, 1'b1);
    chk("first_rgb", bus.rgb_out, 24'hABCDEF);
    run_to(783, 3); step();
    chk("last_x", bus.pix_x, 10'd639);
    chk("last_de", bus.de, 1'b1);
    chk("last_rgb", bus.rgb_out, 24'hC3030F);
    step();
    chk("past_x", bus.pix_x, 10'h3FF);
    chk("past_de", bus.de, 1'b0);
    chk("past_rgb", bus.rgb_out, 24'h0);
    run_to(200, 4); step();
    chk("row1_x", bus.pix_x, 10'd56);
    chk("row1_y", bus.pix_y, 10'd1);

    // frame_start follows a vsync edge seen while locked.
    run_to(0, 0); step();
    chk("fs_pulse", bus.frame_start, 1'b1);
    step();
    chk("fs_clear", bus.frame_start, 1'b0);

    // Line of 799 clocks.
    run_to(0, 2);
    h_len = 799;
    run_to(0, 3);
    chk("short_pre_lock", bus.locked, 1'b1);
    step();
    chk("short_lock", bus.locked, 1'b0);
    chk("short_terr", bus.timing_err, 1'b1);
    chk("short_hmeas", bus.h_total_meas, 11'd799);
    step();
    chk("short_terr_off", bus.timing_err, 1'b0);
    run_to(0, 0); step();
    chk("short_rl0", bus.locked, 1'b0);
    run_to(0, 0); step();
    chk("short_rl1", bus.locked, 1'b0);
    run_to(0, 0); step();
    chk("short_rl2", bus.locked, 1'b1);

    // hsync low for 2100 clocks: counter saturation drops lock.
    run_to(0, 2);
    h_len = 2196;
    run_to(2047, 2);
    chk("ovf_pre_lock", bus.locked, 1'b1);
    step();
    chk("ovf_lock", bus.locked, 1'b0);
    chk("ovf_terr", bus.timing_err, 1'b1);
    step();
    chk("ovf_terr_off", bus.timing_err, 1'b0);
    run_to(0, 3); step();
    chk("ovf_hmeas", bus.h_total_meas, 11'd2047);
    chk("ovf_terr_search", bus.timing_err, 1'b0);
    relock();
    chk("ovf_relock", bus.locked, 1'b1);

    // hsync 95 clocks wide: only fatal with the width check built in.
    run_to(0, 2);
    hs_wd = 95;
    run_to(95, 2); step();
    chk("hsw_lock", bus.locked, WCHK ? 1'b0 : 1'b1);
    chk("hsw_terr", bus.timing_err, WCHK ? 1'b1 : 1'b0);
    run_to(0, 3); step();
    chk("hsw_hmeas", bus.h_total_meas, 11'd800);
    if (WCHK) relock();
    chk("hsw_after", bus.locked, 1'b1);

    // Reset mid-frame on an active pixel.
    run_to(400, 4);
    chk("mid_de", bus.de, 1'b1);
    sys_rst_n = 1'b0;
    #1;
    chk("mrst_lock", bus.locked, 1'b0);
    chk("mrst_de", bus.de, 1'b0);
    chk("mrst_x", bus.pix_x, 10'h3FF);
    chk("mrst_y", bus.pix_y, 10'h3FF);
    chk("mrst_rgb", bus.rgb_out, 24'h0);
    chk("mrst_terr", bus.timing_err, 1'b0);
    chk("mrst_hmeas", bus.h_total_meas, 11'd0);
    chk("mrst_vmeas", bus.v_total_meas, 11'd0);
    step();
    step();
    sys_rst_n = 1'b1;
    step();
    chk("mrst_post_terr", bus.timing_err, 1'b0);
    chk("mrst_post_lock", bus.locked, 1'b0);
    run_to(0, 0); step();
    chk("mrst_rl0", bus.locked, 1'b0);
    run_to(0, 0); step();
    chk("mrst_rl1", bus.locked, 1'b0);
    run_to(0, 0); step();
    chk("mrst_rl2", bus.locked, 1'b1);
    chk("mrst_vmeas2", bus.v_total_meas, 11'd5);
    chk("mrst_hmeas2", bus.h_total_meas, 11'd800);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
